// File: rtl/data_memory_stack_unit_pkg.sv
// mem_pkg: shared encodings for the data-memory/stack responder.
package mem_pkg;
   localparam logic [1:0] ST_PUSH = 2'b00;
   localparam logic [1:0] ST_POP  = 2'b01;
   localparam logic [1:0] ST_RET  = 2'b10;
   localparam logic [1:0] ST_NONE = 2'b11;
   localparam logic MEMIN_RD   = 1'b0;
   localparam logic MEMIN_PC   = 1'b1;
   localparam logic ADDR_ALU   = 1'b0;
   localparam logic ADDR_STACK = 1'b1;
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
endpackage

// File: rtl/data_memory_stack_unit_if.sv
// data_memory_stack_unit_if: sequencer-to-memory request/response bundle.
interface data_memory_stack_unit_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
   logic              start, mem_rd, mem_wr, mem_in, mem_address;
   logic [1:0]        st_op;
   logic [DATA_W-1:0] alu_result, rd_data, pc_next, rdata;
   logic              done, busy, err;
   logic [ADDR_W-1:0] sp;
   modport master (output start, mem_rd, mem_wr, mem_in, mem_address, st_op, alu_result, rd_data, pc_next,
                   input rdata, done, busy, err, sp);
   modport slave (input start, mem_rd, mem_wr, mem_in, mem_address, st_op, alu_result, rd_data, pc_next,
                  output rdata, done, busy, err, sp);
endinterface

// File: rtl/data_memory_stack_unit_ram.sv
// data_ram: single-port synchronous RAM with registered read data.
module data_ram #(parameter int DATA_W = 32, parameter int ADDR_W = 8) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
      rdata <= r_mem[addr];
   end
endmodule

// File: rtl/data_memory_stack_unit.sv
// data_memory_stack_unit: load/store and stack access responder owning the stack pointer.
module data_memory_stack_unit import mem_pkg::*; #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int STACK_BASE  = 'hC0,
   parameter int STACK_DEPTH = 64
) (
   input logic clk,
   input logic rst_n,
   data_memory_stack_unit_if.slave io_bus
);
   localparam logic [ADDR_W-1:0] SP_BASE = ADDR_W'(STACK_BASE);
   localparam logic [ADDR_W-1:0] SP_TOP  = ADDR_W'(STACK_BASE + STACK_DEPTH);
   state_t            r_state, w_next;
   logic              r_rd, r_wr, r_stack, r_err;
   logic [ADDR_W-1:0] r_sp, r_addr, w_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata, w_q;
   logic              w_err, w_we, w_rd_ok, w_stk_wr, w_stk_rd, w_unused;
   assign w_unused = ^io_bus.alu_result[DATA_W-1:ADDR_W];
   assign w_stk_wr = io_bus.mem_address == ADDR_STACK && io_bus.mem_wr;
   assign w_stk_rd = io_bus.mem_address == ADDR_STACK && io_bus.mem_rd;
   // sp cannot move while a request is in flight, so error and address are resolved at start
   assign w_err = (io_bus.mem_rd && io_bus.mem_wr)
                || (w_stk_wr && (io_bus.st_op != ST_PUSH || r_sp == SP_TOP))
                || (w_stk_rd && (!(io_bus.st_op == ST_POP || io_bus.st_op == ST_RET) || r_sp == SP_BASE));
   assign w_addr = io_bus.mem_address == ADDR_ALU ? io_bus.alu_result[ADDR_W-1:0]
                 : io_bus.mem_wr ? r_sp : r_sp - ADDR_W'(1);
   assign w_rd_ok = r_state == S_RESP && r_rd && !r_err;
   assign io_bus.rdata = w_rd_ok ? w_q : r_rdata;
   assign io_bus.sp = r_sp;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state == S_IDLE ? (io_bus.start ? S_ACCESS : S_IDLE)
             : r_state == S_ACCESS ? S_RESP : S_IDLE;
      io_bus.done = r_state == S_RESP;
      io_bus.busy = r_state == S_ACCESS;
      io_bus.err = r_state == S_RESP && r_err;
      w_we = r_state == S_ACCESS && r_wr && !r_err;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sp <= SP_BASE;
         r_rdata <= '0;
         r_rd <= 1'b0;
         r_wr <= 1'b0;
         r_stack <= 1'b0;
         r_err <= 1'b0;
         r_addr <= '0;
         r_wdata <= '0;
      end else begin
         if (r_state == S_IDLE && io_bus.start) begin
            r_rd <= io_bus.mem_rd;
            r_wr <= io_bus.mem_wr;
            r_stack <= io_bus.mem_address == ADDR_STACK;
            r_err <= w_err;
            r_addr <= w_addr;
            r_wdata <= io_bus.mem_in == MEMIN_PC ? io_bus.pc_next : io_bus.rd_data;
         end
         if (r_state == S_ACCESS && r_stack && !r_err)
            r_sp <= r_wr ? r_sp + ADDR_W'(1) : r_rd ? r_sp - ADDR_W'(1) : r_sp;
         if (w_rd_ok) r_rdata <= w_q;
      end
   end
   data_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk(clk), .we(w_we), .addr(r_addr), .wdata(r_wdata), .rdata(w_q)
   );
endmodule

// File: tb/tb_data_memory_stack_unit.sv
// tb_data_memory_stack_unit: directed requests with a scoreboard-driven response monitor.
module tb_data_memory_stack_unit;
   typedef struct {logic [31:0] rdata; logic err; logic [8:0] sp; int cyc;} exp_t;
   logic clk, rst_n;
   int   n_chk = 0, n_err = 0, cyc = 0;
   exp_t sb[$];
   data_memory_stack_unit_if #(.DATA_W(32), .ADDR_W(9)) bus ();
   data_memory_stack_unit #(.DATA_W(32), .ADDR_W(9)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (sb.size() == 0) chk("extra_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("err", bus.err, e.err);
            chk("sp", bus.sp, e.sp);
            chk("latency", cyc, e.cyc);
         end
      end
   end
   task automatic req(input logic rd, input logic wr, input logic mi, input logic ma, input logic [1:0] st,
                      input logic [31:0] alu, input logic [31:0] rdd, input logic [31:0] pc,
                      input logic [31:0] er, input logic ee, input logic [8:0] es);
      @(negedge clk);
      {bus.mem_rd, bus.mem_wr, bus.mem_in, bus.mem_address, bus.st_op} = {rd, wr, mi, ma, st};
      {bus.alu_result, bus.rd_data, bus.pc_next} = {alu, rdd, pc};
      bus.start = 1'b1;
      sb.push_back('{er, ee, es, cyc + 2});
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      int t;
      rst_n = 1'b0;
      {bus.start, bus.mem_rd, bus.mem_wr, bus.mem_in, bus.mem_address, bus.st_op} = '0;
      {bus.alu_result, bus.rd_data, bus.pc_next} = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_sp", bus.sp, 9'h0C0);
      rst_n = 1'b1;
      req(0, 1, 0, 0, 2'b11, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0, 9'h0C0);
      req(1, 0, 0, 0, 2'b11, 32'h10, 0, 0, 32'hDEADBEEF, 0, 9'h0C0);
      req(0, 1, 0, 1, 2'b00, 0, 32'h1234, 0, 32'hDEADBEEF, 0, 9'h0C1);
      req(0, 1, 1, 1, 2'b00, 0, 0, 32'h40, 32'hDEADBEEF, 0, 9'h0C2);
      req(1, 0, 0, 1, 2'b10, 0, 0, 0, 32'h40, 0, 9'h0C1);
      req(1, 0, 0, 1, 2'b01, 0, 0, 0, 32'h1234, 0, 9'h0C0);
      req(1, 0, 0, 1, 2'b01, 0, 0, 0, 32'h1234, 1, 9'h0C0);
      req(1, 1, 0, 0, 2'b11, 32'h10, 32'hBAD, 0, 32'h1234, 1, 9'h0C0);
      req(1, 0, 0, 0, 2'b11, 32'h10, 0, 0, 32'hDEADBEEF, 0, 9'h0C0);
      req(0, 0, 0, 1, 2'b00, 32'h10, 0, 0, 32'hDEADBEEF, 0, 9'h0C0);
      req(0, 1, 0, 1, 2'b01, 0, 32'h77, 0, 32'hDEADBEEF, 1, 9'h0C0);
      // second start while busy must be dropped: only one done, and its store never lands
      @(negedge clk);
      {bus.mem_rd, bus.mem_wr, bus.mem_address, bus.alu_result} = {1'b1, 1'b0, 1'b0, 32'h10};
      bus.start = 1'b1;
      sb.push_back('{32'hDEADBEEF, 1'b0, 9'h0C0, cyc + 2});
      @(negedge clk);
      chk("busy", bus.busy, 1);
      {bus.mem_rd, bus.mem_wr, bus.rd_data} = {1'b0, 1'b1, 32'h55};
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      req(1, 0, 0, 0, 2'b11, 32'h10, 0, 0, 32'hDEADBEEF, 0, 9'h0C0);
      @(negedge clk);
      {bus.mem_rd, bus.mem_wr, bus.mem_in, bus.mem_address, bus.st_op, bus.rd_data} =
         {1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h9999};
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_sp", bus.sp, 9'h0C0);
      chk("midrst_rdata", bus.rdata, 0);
      repeat (2) @(negedge clk);
      req(1, 0, 0, 0, 2'b11, 32'hC0, 0, 0, 32'h1234, 0, 9'h0C0);
      for (int i = 0; i < 64; i++)
         req(0, 1, 0, 1, 2'b00, 0, i, 0, 32'h1234, 0, 9'(32'hC1 + i));
      req(0, 1, 0, 1, 2'b00, 0, 32'hFFFF, 0, 32'h1234, 1, 9'h100);
      req(1, 0, 0, 1, 2'b01, 0, 0, 0, 32'd63, 0, 9'h0FF);
      req(1, 0, 0, 0, 2'b11, 32'hC0, 0, 0, 32'd0, 0, 9'h0FF);
      t = 0;
      while (sb.size() > 0 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() > 0) chk("pending_done", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
